// File: rtl/uart_rx_mc_pkg.sv
// Shared types and constants for the multi-config UART receiver.
package uart_rx_mc_pkg;

    // Receiver FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t StIdle   = 3'd0;
    localparam state_t StStart  = 3'd1;
    localparam state_t StData   = 3'd2;
    localparam state_t StParity = 3'd3;
    localparam state_t StStop   = 3'd4;
    localparam state_t StBreak  = 3'd5;

    // FIFO entry = {brk, frm, par, data}; flag offsets counted above the data field
    localparam int unsigned EntryParOfs = 0;
    localparam int unsigned EntryFrmOfs = 1;
    localparam int unsigned EntryBrkOfs = 2;
    localparam int unsigned EntryFlagW  = 3;

    // Majority-vote sample points: idx 0,1,2 -> P/2-1, P/2, P/2+1
    function automatic int unsigned sample_point(int unsigned prescale, int unsigned idx);
        return prescale / 2 - 1 + idx;
    endfunction

endpackage

// File: rtl/uart_rx_mc_fifo.sv
// Synchronous FIFO with registered storage; push while full is accepted only with a pop.
module uart_rx_mc_fifo
    import uart_rx_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned Depth = 2 ** AW;

    logic [WIDTH-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(Depth));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Empty FIFO presents zeros rather than stale storage
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + (AW + 1)'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - (AW + 1)'(1);
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_mc.sv
// Oversampled UART receiver with majority vote, break detection and buffered output.
module uart_rx_mc
    import uart_rx_mc_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  RX_READY,
    output logic                  RX_VALID,
    output logic [DATA_W-1:0]     RX_DATA,
    output logic                  RX_PAR_ERR,
    output logic                  RX_FRM_ERR,
    output logic                  RX_BRK,
    output logic                  OVR_ERR
);

    localparam int unsigned EntryW = DATA_W + EntryFlagW;

    logic                  rx_meta_q, rx_sync_q;
    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic                  par_bit_q, par_bit_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                  commit_q, commit_d;
    logic [EntryW-1:0]     entry_q, entry_d, head;
    logic [PRESCALE_W-1:0] sp_lo, sp_mid, sp_hi, edge_last;
    logic                  at_lo, at_mid, at_hi, at_last, vote, frm_now, fifo_full, fifo_empty, pop;

    assign sp_lo     = PRESCALE_W'(sample_point(32'(Prescale), 0));
    assign sp_mid    = PRESCALE_W'(sample_point(32'(Prescale), 1));
    assign sp_hi     = PRESCALE_W'(sample_point(32'(Prescale), 2));
    assign edge_last = Prescale - PRESCALE_W'(1);
    assign at_lo     = (edge_cnt_q == sp_lo);
    assign at_mid    = (edge_cnt_q == sp_mid);
    assign at_hi     = (edge_cnt_q == sp_hi);
    assign at_last   = (edge_cnt_q == edge_last);
    // Third sample is taken live on the resolving cycle
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
    assign frm_now   = frm_err_q | ~vote;

    // Two-flop synchronizer, idle-high reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Capture the first two vote samples of each bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_q <= 2'b11;
        end else begin
            if (at_lo)  samp_q[0] <= rx_sync_q;
            if (at_mid) samp_q[1] <= rx_sync_q;
        end
    end

    // Frame FSM, counters, shift register and entry assembly
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        commit_d   = 1'b0;
        entry_d    = entry_q;
        if (state_q != StIdle && state_q != StBreak) begin
            edge_cnt_d = at_last ? '0 : edge_cnt_q + PRESCALE_W'(1);
        end
        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_bit_d  = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            StStart: begin
                if (at_hi && vote) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else if (at_last) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_hi) shreg_d = {vote, shreg_q[DATA_W-1:1]};
                if (at_last) begin
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_EN ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (at_hi) begin
                    par_bit_d = vote;
                    par_err_d = (^shreg_q) ^ vote ^ PAR_TYP;
                end
                if (at_last) state_d = StStop;
            end
            StStop: begin
                if (at_hi) begin
                    if (bit_cnt_q == '0 && !vote && shreg_q == '0 && !par_bit_q) begin
                        entry_d                       = '0;
                        entry_d[DATA_W + EntryBrkOfs] = 1'b1;
                        entry_d[DATA_W + EntryFrmOfs] = 1'b1;
                        commit_d                      = 1'b1;
                        state_d                       = StBreak;
                        edge_cnt_d                    = '0;
                    end else if (!STOP2 || bit_cnt_q == 4'd1) begin
                        entry_d                       = '0;
                        entry_d[DATA_W-1:0]           = shreg_q;
                        entry_d[DATA_W + EntryParOfs] = par_err_q;
                        entry_d[DATA_W + EntryFrmOfs] = frm_now;
                        commit_d                      = 1'b1;
                        state_d                       = StIdle;
                        edge_cnt_d                    = '0;
                    end else begin
                        frm_err_d = frm_now;
                    end
                end else if (at_last) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            StBreak: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            commit_q   <= 1'b0;
            entry_q    <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            commit_q   <= commit_d;
            entry_q    <= entry_d;
        end
    end

    assign pop     = RX_VALID && RX_READY;
    assign OVR_ERR = commit_q && fifo_full && !pop;

    uart_rx_mc_fifo #(
        .WIDTH (EntryW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (commit_q),
        .wdata (entry_q),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign RX_VALID   = !fifo_empty;
    assign RX_DATA    = head[DATA_W-1:0];
    assign RX_PAR_ERR = head[DATA_W + EntryParOfs];
    assign RX_FRM_ERR = head[DATA_W + EntryFrmOfs];
    assign RX_BRK     = head[DATA_W + EntryBrkOfs];

endmodule

// File: tb/tb_uart_rx_mc.sv
// Directed/randomized bench for uart_rx_mc: three builds (8, 5 and 9 data bits).
module tb_uart_rx_mc;

    logic       clk, rst, par_en, par_typ, stop2;
    logic [5:0] pre16, pre8;
    logic       rx8, rx5, rx9, rdy8, rdy5, rdy9;
    logic       v8, v5, v9, pe8, pe5, pe9, fe8, fe5, fe9, bk8, bk5, bk9, ovr8, ovr5, ovr9;
    logic [7:0] d8;
    logic [4:0] d5;
    logic [8:0] d9;

    int vectors = 0, miscompares = 0;
    int cyc = 0, rise_cyc = -1, prev_v8 = 0;
    int ovr_cnt8 = 0, ovr_cnt_other = 0, drops8 = 0;
    logic [11:0] q8[$], q5[$], q9[$];

    uart_rx_mc #(.DATA_W(8), .PRESCALE_W(6), .FIFO_AW(2)) dut8 (
        .CLK(clk), .RST(rst), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .Prescale(pre16), .RX_READY(rdy8), .RX_VALID(v8), .RX_DATA(d8), .RX_PAR_ERR(pe8),
        .RX_FRM_ERR(fe8), .RX_BRK(bk8), .OVR_ERR(ovr8));
    uart_rx_mc #(.DATA_W(5), .PRESCALE_W(6), .FIFO_AW(2)) dut5 (
        .CLK(clk), .RST(rst), .RX_IN(rx5), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .Prescale(pre8), .RX_READY(rdy5), .RX_VALID(v5), .RX_DATA(d5), .RX_PAR_ERR(pe5),
        .RX_FRM_ERR(fe5), .RX_BRK(bk5), .OVR_ERR(ovr5));
    uart_rx_mc #(.DATA_W(9), .PRESCALE_W(6), .FIFO_AW(2)) dut9 (
        .CLK(clk), .RST(rst), .RX_IN(rx9), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .Prescale(pre8), .RX_READY(rdy9), .RX_VALID(v9), .RX_DATA(d9), .RX_PAR_ERR(pe9),
        .RX_FRM_ERR(fe9), .RX_BRK(bk9), .OVR_ERR(ovr9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sampled on the inactive edge
    always @(negedge clk) begin
        if (v8 && prev_v8 == 0 && rise_cyc < 0) rise_cyc <= cyc;
        prev_v8 <= int'(v8);
        if (ovr8) ovr_cnt8 <= ovr_cnt8 + 1;
        if (ovr5 || ovr9) ovr_cnt_other <= ovr_cnt_other + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_valid(input int which);
        case (which)
            5:       return v5;
            9:       return v9;
            default: return v8;
        endcase
    endfunction

    function automatic logic [11:0] obs_entry(input int which);
        case (which)
            5:       return {bk5, fe5, pe5, 4'b0, d5};
            9:       return {bk9, fe9, pe9, d9};
            default: return {bk8, fe8, pe8, 1'b0, d8};
        endcase
    endfunction

    task automatic set_line(input int which, input logic b);
        case (which)
            5:       rx5 = b;
            9:       rx9 = b;
            default: rx8 = b;
        endcase
    endtask

    task automatic set_ready(input int which, input logic b);
        case (which)
            5:       rdy5 = b;
            9:       rdy9 = b;
            default: rdy8 = b;
        endcase
    endtask

    // Reference: what a frame with these line bits must produce, under the current config
    function automatic logic [11:0] model_entry(input int w, input logic [8:0] data,
                                                input logic pbit, input logic s1, input logic s2);
        logic [8:0] d;
        int ones;
        logic par, frm;
        d    = data & 9'((1 << w) - 1);
        ones = $countones(d);
        if (d == 0 && (!par_en || !pbit) && !s1) return {3'b110, 9'd0};
        par = par_en && (((ones + int'(pbit)) % 2) != int'(par_typ));
        frm = !s1 || (stop2 && !s2);
        return {1'b0, frm, par, d};
    endfunction

    task automatic model_push(input int which, input logic [11:0] e);
        case (which)
            5: q5.push_back(e);
            9: q9.push_back(e);
            default: begin
                if (q8.size() >= 4) drops8++;
                else q8.push_back(e);
            end
        endcase
    endtask

    // Drive one frame starting at a negedge; optional +-1 cycle jitter on inner edges
    task automatic send_frame(input int which, input int p, input int w, input logic [8:0] data,
                              input logic pbit, input logic s1, input logic s2, input bit jit);
        logic bits [0:15];
        int   offs [0:16];
        int   n;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < w; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (par_en) begin bits[n] = pbit; n++; end
        bits[n] = s1;
        n++;
        if (stop2) begin bits[n] = s2; n++; end
        for (int i = 0; i <= n; i++) offs[i] = (jit && i > 0 && i < n) ? int'($urandom_range(2)) - 1 : 0;
        for (int i = 0; i < n; i++) begin
            set_line(which, bits[i]);
            repeat (p + offs[i+1] - offs[i]) @(negedge clk);
        end
        set_line(which, 1'b1);
    endtask

    task automatic frame(input int which, input int p, input int w, input logic [8:0] data,
                         input logic pbit, input logic s1, input logic s2, input bit jit);
        model_push(which, model_entry(w, data, pbit, s1, s2));
        send_frame(which, p, w, data, pbit, s1, s2, jit);
    endtask

    task automatic check_head(input int which, input string tag);
        int k;
        logic [11:0] exp;
        k = 0;
        while (!obs_valid(which) && k < 640) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, 32'(obs_valid(which)), 32'd1);
        exp = 12'hfff;
        case (which)
            5:       if (q5.size() > 0) exp = q5.pop_front();
            9:       if (q9.size() > 0) exp = q9.pop_front();
            default: if (q8.size() > 0) exp = q8.pop_front();
        endcase
        chk(tag, 32'(obs_entry(which)), 32'(exp));
        if (obs_valid(which)) begin
            set_ready(which, 1'b1);
            @(negedge clk);
            set_ready(which, 1'b0);
        end
    endtask

    initial begin
        logic [8:0] d;
        int t_start;
        rst = 1'b1;
        {rx8, rx5, rx9} = 3'b111;
        {rdy8, rdy5, rdy9} = 3'b000;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        pre16 = 6'd16; pre8 = 6'd8;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v8), 32'd0);
        chk("rst_head", 32'(obs_entry(8)), 32'd0);
        chk("rst_ovr", 32'({ovr8, ovr5, ovr9}), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_valid", 32'({v8, v5, v9}), 32'd0);

        // 8N1 0xA5 with commit-to-valid latency
        t_start = cyc;
        rise_cyc = -1;
        frame(8, 16, 8, 9'h0A5, 1'b0, 1'b1, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("a5_latency", 32'(rise_cyc - t_start), 32'(6 + 9 * 16 + 16 / 2));
        check_head(8, "a5");

        // Odd parity selected, even parity bit sent
        par_en = 1'b1; par_typ = 1'b1;
        frame(8, 16, 8, 9'h03C, 1'b0, 1'b1, 1'b1, 0);
        check_head(8, "par_3c");

        // Two stop bits, second one low
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1;
        frame(8, 16, 8, 9'h0C3, 1'b0, 1'b1, 1'b0, 0);
        check_head(8, "stop2_frm");
        repeat (48) @(negedge clk);
        chk("stop2_tail_no_entry", 32'(v8), 32'd0);
        stop2 = 1'b0;

        // Short start glitch
        rx8 = 1'b0;
        repeat (2) @(negedge clk);
        rx8 = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch_no_entry", 32'(v8), 32'd0);

        // Break: line low for two frame times
        model_push(8, model_entry(8, 9'h000, 1'b0, 1'b0, 1'b0));
        rx8 = 1'b0;
        repeat (2 * 10 * 16) @(negedge clk);
        rx8 = 1'b1;
        repeat (32) @(negedge clk);
        check_head(8, "break");
        repeat (4) @(negedge clk);
        chk("break_single", 32'(v8), 32'd0);
        frame(8, 16, 8, 9'h055, 1'b0, 1'b1, 1'b1, 0);
        check_head(8, "after_break_55");

        // Random configs on the 8-bit build
        for (int i = 0; i < 6; i++) begin
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
            stop2   = 1'($urandom);
            frame(8, 16, 8, 9'($urandom), 1'($urandom), 1'b1, 1'($urandom), 0);
            repeat (32) @(negedge clk);
            check_head(8, "rand8");
        end
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        repeat (32) @(negedge clk);

        // Overflow: five back-to-back frames with no consumer
        for (int i = 0; i < 5; i++) frame(8, 16, 8, 9'($urandom), 1'b0, 1'b1, 1'b1, 0);
        repeat (32) @(negedge clk);
        chk("ovr_pulses", 32'(ovr_cnt8), 32'(drops8));
        for (int i = 0; i < 4; i++) check_head(8, "drain");
        @(negedge clk);
        chk("drain_empty", 32'(v8), 32'd0);

        // 5- and 9-bit builds at P=8 with edge jitter
        for (int i = 0; i < 4; i++) begin
            frame(5, 8, 5, 9'($urandom), 1'b0, 1'b1, 1'b1, 1);
            repeat (16) @(negedge clk);
            check_head(5, "jit5");
        end
        par_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            par_typ = 1'($urandom);
            frame(9, 8, 9, 9'($urandom), 1'($urandom), 1'b1, 1'b1, 1);
            repeat (16) @(negedge clk);
            check_head(9, "jit9");
        end
        par_en = 1'b0; par_typ = 1'b0;

        // Reset mid-frame with an entry already buffered
        send_frame(8, 16, 8, 9'h0E7, 1'b0, 1'b1, 1'b1, 0);
        repeat (8) @(negedge clk);
        rx8 = 1'b0;
        repeat (4 * 16) @(negedge clk);
        rst = 1'b1;
        rx8 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(v8), 32'd0);
        chk("midrst_head", 32'(obs_entry(8)), 32'd0);
        repeat (48) @(negedge clk);
        chk("midrst_no_entry", 32'(v8), 32'd0);
        d = 9'($urandom);
        frame(8, 16, 8, d, 1'b0, 1'b1, 1'b1, 0);
        check_head(8, "post_rst");

        chk("ovr_other", 32'(ovr_cnt_other), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_mc.md
# uart_rx_mc

Parametrised successor of the system UART receiver: oversampled asynchronous serial receiver with configurable data width, 1/2 stop bits, majority-vote sampling, break detection and an output FIFO with valid/ready handshake. Sits in the UART clock domain between the pad-side RX_IN line and the system-side consumer. Replaces the single-register P_DATA/Data_valid pulse interface with buffered, per-frame status.

## Interface
- DATA_W, 8, data bits per frame; legal 5..9.
- PRESCALE_W, 6, width of Prescale input.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.
- CLK  in  1  oversampling clock.
- RST  in  1  reset; asynchronous, active-high.
- RX_IN  in  1  serial line, idle high, asynchronous to CLK.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits expected.
- Prescale  in  PRESCALE_W  CLK cycles per bit; legal even values >= 6.
- RX_READY  in  1  consumer accepts head entry.
- RX_VALID  out  1  FIFO non-empty.
- RX_DATA  out  DATA_W  head entry data, LSB = first received bit.
- RX_PAR_ERR  out  1  head entry parity error.
- RX_FRM_ERR  out  1  head entry stop-bit error.
- RX_BRK  out  1  head entry is a break.
- OVR_ERR  out  1  one-cycle pulse: completed frame dropped, FIFO full.
- Configuration inputs are quasi-static; changes are legal only while the FSM is in IDLE.

## Operation
- RX_IN passes a 2-flop synchronizer; flops reset to 1.
- Edge counter 0..Prescale-1 per bit; bit counter counts data bits.
- Bit value = majority of synchronized samples at edge counts P/2-1, P/2, P/2+1 (P = Prescale), resolved at P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: synchronized 0 -> START, edge counter cleared to 0 on that cycle.
- START: voted 1 -> IDLE (glitch, no entry); voted 0 -> DATA at edge P-1.
- DATA: DATA_W bits LSB-first into shift register -> PARITY if PAR_EN, else STOP.
- PARITY: error if data XOR parity bit XOR PAR_TYP != 0.
- STOP: one or two (STOP2) stop bits; any voted 0 sets frame error.
- Frame commit: cycle after last stop bit's vote; FSM returns to IDLE on the same cycle (line may start a new frame in the remaining half bit).
- Break: data all 0, parity (if present) 0, first stop 0 -> entry with data 0, RX_BRK=1, RX_FRM_ERR=1, RX_PAR_ERR=0; FSM -> BREAK, stays until synchronized RX_IN = 1, then IDLE.
- FIFO entry = {brk, frm, par, data}; push on commit; pop on RX_VALID && RX_READY.
- Full and commit without pop: entry dropped, OVR_ERR pulses; FIFO content unchanged.
- Full, commit and pop same cycle: push accepted, count unchanged.
- Reset mid-frame: FSM to IDLE, FIFO emptied, partial frame discarded.

## Timing
- Reset values: RX_VALID 0, RX_DATA 0, RX_PAR_ERR 0, RX_FRM_ERR 0, RX_BRK 0, OVR_ERR 0; FSM IDLE; counters 0.
- Start-edge detection: 2 CLK after RX_IN falls (synchronizer).
- RX_VALID rises 1 CLK after commit (registered FIFO, no bypass).
- Head outputs are stable while RX_VALID && !RX_READY.
- Pop takes effect on the same edge; next head is visible the following cycle.
- Throughput: back-to-back frames at full line rate with 1 stop bit, no loss while the FIFO is not full.

## Structure
- Package uart_rx_mc_pkg: FSM state enum, entry field index constants, sample-point helper function (P/2-1, P/2, P/2+1).
- Sub-module uart_rx_mc_fifo: synchronous FIFO, parametrised width/depth, full/empty, simultaneous push/pop.
- Synchronizer, counters, voter, FSM and shift register live in the top module.

## Test plan
- DATA_W=8, P=16, PAR_EN=0, 0xA5 -> one entry 0xA5, all flags 0, RX_VALID 1 CLK after commit.
- PAR_EN=1, PAR_TYP=1, 0x3C with even parity bit sent -> entry 0x3C, RX_PAR_ERR=1.
- STOP2=1, second stop bit driven 0 -> RX_FRM_ERR=1, data intact; 2-cycle low start pulse -> no entry.
- Line held low 2 frame times, then high -> exactly one entry with RX_BRK=1, data 0, FRM=1; next frame 0x55 received correctly.
- RX_READY=0, 5 frames into depth-4 FIFO -> 4 entries held, OVR_ERR one pulse on fifth commit; drain order intact.
- DATA_W=5 and DATA_W=9 builds, 1-cycle jitter on each edge at P=8 -> correct data via majority vote; RST mid-frame -> RX_VALID 0, next frame clean.
